native_2_axis_fifo: RTL

- Downstream companion of the AXI4-Stream to native adapter. Accepts flits on the native flow-control interface into a small buffer and re-emits them as an AXI4-Stream (tid/tdest/tdata/tlast) master.
- Native tready is registered and asserted while free space remains, so it must deassert early. Slack entries absorb flits already in flight after tready drops.
- Sits at the egress of a NoC/native path, in front of AXIS consumers (DMA, CDC FIFO, IP cores).

---
 rtl/noc_axis_pkg.sv | 38 +++
 rtl/native_fifo_mem.sv | 39 +++
 rtl/native_2_axis_fifo.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/noc_axis_pkg.sv
// -----------------------------------------------------------------------------
// noc_axis_pkg
//   Shared definitions for the native <-> AXI4-Stream adapters.
//   - Default field widths and the matching entry width (EntryW).
//   - entry_width(): entry width for any field-width combination, used by
//     parameterised modules that override the defaults.
//   - entry_t plus pack/unpack helpers for the default configuration. The
//     packed order is {tid, tdest, tdata, tlast}, so tlast is bit 0.
// -----------------------------------------------------------------------------
package noc_axis_pkg;

    localparam int DefSTDataWidth = 32;
    localparam int DefTidWidth    = 8;
    localparam int DefTdestWidth  = 8;

    localparam int EntryW = DefTidWidth + DefTdestWidth + DefSTDataWidth + 1;

    typedef struct packed {
        logic [DefTidWidth-1:0]    tid;
        logic [DefTdestWidth-1:0]  tdest;
        logic [DefSTDataWidth-1:0] tdata;
        logic                      tlast;
    } entry_t;

    // Width of one stored flit for arbitrary field widths.
    function automatic int entry_width(input int tid_w, input int tdest_w, input int data_w);
        return tid_w + tdest_w + data_w + 1;
    endfunction

    function automatic logic [EntryW-1:0] pack_entry(input entry_t e);
        return e;
    endfunction

    function automatic entry_t unpack_entry(input logic [EntryW-1:0] v);
        return v;
    endfunction

endpackage

// File: rtl/native_fifo_mem.sv
// -----------------------------------------------------------------------------
// native_fifo_mem
//   Simple dual-port register array: Depth x Width storage, synchronous write,
//   asynchronous (combinational) read by address. Contents are not reset.
//
// Ports
//   aclk     in   clock
//   wr_en    in   write strobe for this cycle
//   wr_addr  in   write address
//   wr_data  in   write data
//   rd_addr  in   read address
//   rd_data  out  contents at rd_addr, combinational
// -----------------------------------------------------------------------------
module native_fifo_mem #(
    parameter int Depth = 8,
    parameter int Width = 49,
    localparam int AddrW = $clog2(Depth)
) (
    input  logic             aclk,
    input  logic             wr_en,
    input  logic [AddrW-1:0] wr_addr,
    input  logic [Width-1:0] wr_data,
    input  logic [AddrW-1:0] rd_addr,
    output logic [Width-1:0] rd_data
);

    logic [Width-1:0] mem_q [Depth];

    // NOTE: storage is deliberately left out of reset; validity is tracked by
    // the pointers and count, so resetting the array would only add reset fan-out.
    always_ff @(posedge aclk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/native_2_axis_fifo.sv
// -----------------------------------------------------------------------------
// native_2_axis_fifo
//   Accepts flits on a native valid/ready interface into a small buffer and
//   re-emits them as an AXI4-Stream master (first-word-fall-through).
//   s_native_tready is registered, so it falls while Slack entries are still
//   free; those entries absorb flits already in flight from the upstream.
//   A flit arriving with no room is dropped and sets the sticky overflow flag.
//
//   Parameter constraints: FifoDepth is a power of 2 and >= 4;
//   1 <= Slack < FifoDepth.
//
// Ports
//   aclk             in   clock
//   rst              in   synchronous reset, active-high
//   s_native_tid     in   stream identifier
//   s_native_tdest   in   destination
//   s_native_tdata   in   payload
//   s_native_tlast   in   packet boundary
//   s_native_tvalid  in   write strobe, one flit per cycle high
//   s_native_tready  out  space available (registered)
//   m_axis_tid       out  head entry tid
//   m_axis_tdest     out  head entry tdest
//   m_axis_tdata     out  head entry tdata
//   m_axis_tlast     out  head entry tlast
//   m_axis_tvalid    out  buffer not empty
//   m_axis_tready    in   downstream accepts
//   fill_level       out  current entry count
//   overflow         out  sticky, a flit was dropped
// -----------------------------------------------------------------------------
module native_2_axis_fifo
    import noc_axis_pkg::*;
#(
    parameter int STDataWidth = 32,
    parameter int TidWidth    = 8,
    parameter int TdestWidth  = 8,
    parameter int FifoDepth   = 8,
    parameter int Slack       = 2,
    localparam int PtrW       = $clog2(FifoDepth),
    localparam int CntW       = $clog2(FifoDepth) + 1
) (
    input  logic                   aclk,
    input  logic                   rst,

    input  logic [TidWidth-1:0]    s_native_tid,
    input  logic [TdestWidth-1:0]  s_native_tdest,
    input  logic [STDataWidth-1:0] s_native_tdata,
    input  logic                   s_native_tlast,
    input  logic                   s_native_tvalid,
    output logic                   s_native_tready,

    output logic [TidWidth-1:0]    m_axis_tid,
    output logic [TdestWidth-1:0]  m_axis_tdest,
    output logic [STDataWidth-1:0] m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,

    output logic [CntW-1:0]        fill_level,
    output logic                   overflow
);

    localparam int EntryWidth = entry_width(TidWidth, TdestWidth, STDataWidth);

    localparam logic [CntW-1:0] CntFull   = CntW'(FifoDepth);
    localparam logic [CntW-1:0] CntThresh = CntW'(FifoDepth - Slack);

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q,  count_d;
    logic            tready_q, tready_d;
    logic            overflow_q, overflow_d;

    logic            do_write;
    logic            do_read;

    logic [EntryWidth-1:0] wr_entry;
    logic [EntryWidth-1:0] rd_entry;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        do_read  = m_axis_tvalid && m_axis_tready;
        // Writes ignore our own tready: a full buffer still accepts when the
        // head leaves in the same cycle, otherwise the flit is lost.
        do_write = s_native_tvalid && ((count_q < CntFull) || do_read);

        if (s_native_tvalid && !do_write) begin
            overflow_d = 1'b1;
        end

        if (do_write) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_read) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end

        unique case ({do_write, do_read})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // Registered from the post-edge count so tready reflects the
        // occupancy the upstream will actually see next cycle.
        tready_d = (count_d <= CntThresh);
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge aclk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tready_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tready_q   <= tready_d;
            overflow_q <= overflow_d;
        end
    end

    // ---------------------------------------------------------------------
    // Storage
    // ---------------------------------------------------------------------
    assign wr_entry = {s_native_tid, s_native_tdest, s_native_tdata, s_native_tlast};

    native_fifo_mem #(
        .Depth (FifoDepth),
        .Width (EntryWidth)
    ) u_mem (
        .aclk    (aclk),
        .wr_en   (do_write),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_entry)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // Head entry falls through combinationally from the read pointer; it only
    // changes on a read, so it is stable while the downstream stalls.
    assign m_axis_tid    = rd_entry[EntryWidth-1 -: TidWidth];
    assign m_axis_tdest  = rd_entry[EntryWidth-1-TidWidth -: TdestWidth];
    assign m_axis_tdata  = rd_entry[STDataWidth:1];
    assign m_axis_tlast  = rd_entry[0];

    // Derived from the count register, so a write at t shows up at t+1.
    assign m_axis_tvalid   = (count_q != '0);
    assign s_native_tready = tready_q;
    assign fill_level      = count_q;
    assign overflow        = overflow_q;

endmodule
